// File: rtl/mips_mem_arbiter.sv
// Unified instruction/data memory: round-robin arbitration between fetch and data
// ports, byte-enabled writes, programmable wait states and req/ready handshakes.
//
// state  | meaning
// IDLE   | no transaction in flight; arbitrate pending requests
// ACCESS | request latched; count down wait states, commit when cnt hits 0
// RESP   | commit done; one-cycle ready pulse on the granted port
module mips_mem_arbiter #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH       = 4096,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                busy
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateE;

  stateE             state;
  stateE             stateNext;
  logic [3:0]        cnt;
  logic              lastGrantD;
  logic              grantD;
  logic              weQ;
  logic [BE_W-1:0]   beQ;
  logic [IDX_W-1:0]  idxQ;
  logic [DATA_W-1:0] wdataQ;
  logic              anyReq;
  logic              pickD;
  logic              commit;
  logic [DATA_W-1:0] mem [DEPTH];

  assign anyReq = i_req | d_req;
  // On a tie the port that did not win last time takes the grant.
  assign pickD  = d_req & (~i_req | ~lastGrantD);

  // Address bits outside the word index are don't-care (aliasing).
  logic unusedAddrBits;
  assign unusedAddrBits = ^{i_addr[31:IDX_W+2], i_addr[1:0], d_addr[31:IDX_W+2], d_addr[1:0]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  if (cnt == 4'd0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    commit  = 1'b0;
    case (state)
      ACCESS:  commit = (cnt == 4'd0);
      RESP: begin
        i_ready = ~grantD;
        d_ready = grantD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt        <= 4'd0;
      lastGrantD <= 1'b0;
      grantD     <= 1'b0;
      weQ        <= 1'b0;
      beQ        <= '0;
      idxQ       <= '0;
      wdataQ     <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      busy <= (stateNext != IDLE);
      if (state == IDLE && anyReq) begin
        cnt        <= 4'(WAIT_CYCLES);
        lastGrantD <= pickD;
        grantD     <= pickD;
        weQ        <= pickD & d_we;
        beQ        <= d_be;
        idxQ       <= pickD ? d_addr[IDX_W+1:2] : i_addr[IDX_W+1:2];
        wdataQ     <= d_wdata;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !weQ) begin
        if (grantD) d_rdata <= mem[idxQ];
        else        i_rdata <= mem[idxQ];
      end
    end
  end

  // No reset on the array: contents survive RST, and RST forces IDLE so an
  // aborted access never reaches its commit edge.
  always_ff @(posedge CLK) begin
    if (commit && weQ) begin
      for (int b = 0; b < BE_W; b++) begin
        if (beQ[b]) mem[idxQ][b*8 +: 8] <= wdataQ[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: two instances (no wait states / deep, and three
// wait states / 16 words) checked each cycle against a transaction-level model.
module tb_mips_mem_arbiter;
  localparam int W0 = 0;
  localparam int D0 = 4096;
  localparam int W1 = 3;
  localparam int D1 = 16;

  logic        CLK = 1'b0;
  logic        rst    [2];
  logic        iReq   [2];
  logic        dReq   [2];
  logic        dWe    [2];
  logic [3:0]  dBe    [2];
  logic [31:0] iAddr  [2];
  logic [31:0] dAddr  [2];
  logic [31:0] dWdata [2];
  logic [31:0] iRdata [2];
  logic [31:0] dRdata [2];
  logic        iReady [2];
  logic        dReady [2];
  logic        busy   [2];

  always #5 CLK = ~CLK;

  mips_mem_arbiter #(.DATA_W(32), .DEPTH(D0), .WAIT_CYCLES(W0), .INIT_FILE("")) dutA (
    .CLK(CLK), .RST(rst[0]),
    .i_req(iReq[0]), .i_addr(iAddr[0]), .i_rdata(iRdata[0]), .i_ready(iReady[0]),
    .d_req(dReq[0]), .d_we(dWe[0]), .d_be(dBe[0]), .d_addr(dAddr[0]), .d_wdata(dWdata[0]),
    .d_rdata(dRdata[0]), .d_ready(dReady[0]), .busy(busy[0])
  );

  mips_mem_arbiter #(.DATA_W(32), .DEPTH(D1), .WAIT_CYCLES(W1), .INIT_FILE("")) dutB (
    .CLK(CLK), .RST(rst[1]),
    .i_req(iReq[1]), .i_addr(iAddr[1]), .i_rdata(iRdata[1]), .i_ready(iReady[1]),
    .d_req(dReq[1]), .d_we(dWe[1]), .d_be(dBe[1]), .d_addr(dAddr[1]), .d_wdata(dWdata[1]),
    .d_rdata(dRdata[1]), .d_ready(dReady[1]), .busy(busy[1])
  );

  // Reference model: one outstanding transaction per instance, described by the
  // cycle it was granted in and the cycle its ready pulse is due.
  logic [31:0] mm [int];
  bit          pendActive [2];
  bit          pendD      [2];
  bit          pendWe     [2];
  logic [3:0]  pendBe     [2];
  int          pendIdx    [2];
  logic [31:0] pendWd     [2];
  int          readyCyc   [2];
  bit          lastD      [2];
  bit          expBusy    [2];
  bit          expIRdy    [2];
  bit          expDRdy    [2];
  logic [31:0] expIRd     [2];
  logic [31:0] expDRd     [2];
  bit          obsIRdy    [2];
  bit          obsDRdy    [2];
  bit          obsBusy    [2];
  logic [31:0] obsIRd     [2];
  logic [31:0] obsDRd     [2];
  int          cyc;
  int          vecs;
  int          miss;

  function automatic int waitOf(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic int depthOf(input int d);
    return (d == 0) ? D0 : D1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic step(input int d);
    bit          idle;
    bit          winD;
    int          key;
    logic [31:0] w;
    idle = !pendActive[d];
    if (pendActive[d] && cyc + 1 == readyCyc[d]) begin
      key = d * 65536 + pendIdx[d];
      if (pendWe[d]) begin
        w = mm.exists(key) ? mm[key] : 32'hxxxxxxxx;
        for (int b = 0; b < 4; b++) if (pendBe[d][b]) w[b*8 +: 8] = pendWd[d][b*8 +: 8];
        mm[key] = w;
      end else if (pendD[d]) begin
        expDRd[d] = mm.exists(key) ? mm[key] : 32'hxxxxxxxx;
      end else begin
        expIRd[d] = mm.exists(key) ? mm[key] : 32'hxxxxxxxx;
      end
    end
    if (pendActive[d] && cyc == readyCyc[d]) pendActive[d] = 1'b0;
    if (idle && (iReq[d] || dReq[d])) begin
      winD          = dReq[d] && (!iReq[d] || !lastD[d]);
      lastD[d]      = winD;
      pendD[d]      = winD;
      pendWe[d]     = winD && dWe[d];
      pendBe[d]     = dBe[d];
      pendWd[d]     = dWdata[d];
      pendIdx[d]    = int'(((winD ? dAddr[d] : iAddr[d]) >> 2) & 32'(depthOf(d) - 1));
      readyCyc[d]   = cyc + waitOf(d) + 2;
      pendActive[d] = 1'b1;
    end
    expBusy[d] = pendActive[d];
    expIRdy[d] = pendActive[d] && !pendD[d] && (cyc + 1 == readyCyc[d]);
    expDRdy[d] = pendActive[d] &&  pendD[d] && (cyc + 1 == readyCyc[d]);
  endtask

  task automatic modelCycle();
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        pendActive[d] = 1'b0;
        lastD[d]      = 1'b0;
        expBusy[d]    = 1'b0;
        expIRdy[d]    = 1'b0;
        expDRdy[d]    = 1'b0;
        expIRd[d]     = '0;
        expDRd[d]     = '0;
      end
      obsIRdy[d] = iReady[d];
      obsDRdy[d] = dReady[d];
      obsBusy[d] = busy[d];
      obsIRd[d]  = iRdata[d];
      obsDRd[d]  = dRdata[d];
      chk("busy", d, 32'(busy[d]), 32'(expBusy[d]));
      chk("i_ready", d, 32'(iReady[d]), 32'(expIRdy[d]));
      chk("d_ready", d, 32'(dReady[d]), 32'(expDRdy[d]));
      if (!$isunknown(expIRd[d])) chk("i_rdata", d, iRdata[d], expIRd[d]);
      if (!$isunknown(expDRd[d])) chk("d_rdata", d, dRdata[d], expDRd[d]);
      if (rst[d]) step(d);
    end
    cyc++;
  endtask

  task automatic tick();
    modelCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic doTxn(input int d, input bit isD, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat, output int busyCnt);
    bit done;
    done = 1'b0;
    lat = -1;
    busyCnt = 0;
    rd = '0;
    if (isD) begin
      dReq[d] = 1'b1; dWe[d] = we; dBe[d] = be; dAddr[d] = addr; dWdata[d] = wd;
    end else begin
      iReq[d] = 1'b1; iAddr[d] = addr;
    end
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      busyCnt += int'(obsBusy[d]);
      if (isD ? obsDRdy[d] : obsIRdy[d]) begin
        done = 1'b1;
        lat  = n;
        rd   = isD ? obsDRd[d] : obsIRd[d];
      end
    end
    if (isD) dReq[d] = 1'b0;
    else     iReq[d] = 1'b0;
    if (!done) begin
      vecs++;
      miss++;
      $display("FAIL txn_timeout dut%0d: no ready within 40 cycles, expected one", d);
    end
  endtask

  task automatic arbRound();
    int iLat, dLat, first;
    bit iDone, dDone;
    iLat = -1; dLat = -1; first = -1; iDone = 1'b0; dDone = 1'b0;
    iReq[0] = 1'b1; iAddr[0] = 32'h10;
    dReq[0] = 1'b1; dWe[0] = 1'b0; dBe[0] = 4'h0; dAddr[0] = 32'h20;
    for (int n = 0; n < 40 && !(iDone && dDone); n++) begin
      tick();
      chk("arb_no_overlap", 0, 32'(obsIRdy[0] & obsDRdy[0]), 32'd0);
      if (obsDRdy[0] && !dDone) begin
        dDone = 1'b1; dLat = n; dReq[0] = 1'b0;
        if (first < 0) first = 1;
        chk("arb_d_rdata", 0, obsDRd[0], 32'h11BB33DD);
      end
      if (obsIRdy[0] && !iDone) begin
        iDone = 1'b1; iLat = n; iReq[0] = 1'b0;
        if (first < 0) first = 0;
        chk("arb_i_rdata", 0, obsIRd[0], 32'hDEADBEEF);
      end
    end
    iReq[0] = 1'b0;
    dReq[0] = 1'b0;
    chk("arb_first_is_data", 0, first, 32'd1);
    chk("arb_d_latency", 0, dLat, 32'd2);
    chk("arb_i_latency", 0, iLat, 32'd5);
  endtask

  function automatic logic [31:0] rndAddr();
    return ($urandom & 32'hFFFFC03C) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] rd;
    int          lat;
    int          bc;
    bit          act [2][2];
    int          stuck;
    vecs = 0; miss = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; iReq[d] = 1'b0; dReq[d] = 1'b0; dWe[d] = 1'b0; dBe[d] = 4'h0;
      iAddr[d] = '0; dAddr[d] = '0; dWdata[d] = '0;
      act[d][0] = 1'b0; act[d][1] = 1'b0;
    end
    @(posedge CLK);
    #1;
    tick();
    tick();
    chk("rst_busy", 0, 32'(obsBusy[0]), 32'd0);
    chk("rst_d_ready", 0, 32'(obsDRdy[0]), 32'd0);
    chk("rst_d_rdata", 0, obsDRd[0], 32'd0);
    chk("rst_i_rdata", 1, obsIRd[1], 32'd0);
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    doTxn(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat, bc);
    chk("wr_latency", 0, lat, 32'd2);
    doTxn(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, rd, lat, bc);
    chk("rd_data", 0, rd, 32'hDEADBEEF);
    chk("rd_latency", 0, lat, 32'd2);
    doTxn(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, rd, lat, bc);
    doTxn(0, 1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, lat, bc);
    doTxn(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, rd, lat, bc);
    chk("be_merge", 0, rd, 32'h11BB33DD);
    doTxn(0, 1'b1, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, lat, bc);
    chk("wr_keeps_d_rdata", 0, rd, 32'h11BB33DD);
    doTxn(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, rd, lat, bc);
    chk("be_zero_no_change", 0, rd, 32'h11BB33DD);

    rst[0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    for (int r = 0; r < 4; r++) arbRound();

    doTxn(1, 1'b1, 1'b1, 4'hF, 32'h4, 32'hCAFEF00D, rd, lat, bc);
    doTxn(1, 1'b0, 1'b0, 4'h0, 32'h4, 32'h0, rd, lat, bc);
    chk("fetch_rdata", 1, rd, 32'hCAFEF00D);
    chk("fetch_latency", 1, lat, 32'd5);
    chk("fetch_busy_cycles", 1, bc, 32'd5);
    doTxn(1, 1'b1, 1'b1, 4'hF, 32'h04, 32'h5A5A5A5A, rd, lat, bc);
    doTxn(1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0, rd, lat, bc);
    chk("alias_rdata", 1, rd, 32'h5A5A5A5A);

    doTxn(1, 1'b1, 1'b1, 4'hF, 32'h08, 32'h0, rd, lat, bc);
    dReq[1] = 1'b1; dWe[1] = 1'b1; dBe[1] = 4'hF; dAddr[1] = 32'h08; dWdata[1] = 32'hFFFFFFFF;
    tick();
    tick();
    #2;
    rst[1] = 1'b0;
    dReq[1] = 1'b0;
    #1;
    chk("abort_busy", 1, 32'(busy[1]), 32'd0);
    chk("abort_i_ready", 1, 32'(iReady[1]), 32'd0);
    chk("abort_d_ready", 1, 32'(dReady[1]), 32'd0);
    chk("abort_i_rdata", 1, iRdata[1], 32'd0);
    chk("abort_d_rdata", 1, dRdata[1], 32'd0);
    tick();
    tick();
    rst[1] = 1'b1;
    doTxn(1, 1'b1, 1'b0, 4'h0, 32'h08, 32'h0, rd, lat, bc);
    chk("abort_no_write", 1, rd, 32'd0);

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        doTxn(d, 1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom, rd, lat, bc);

    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (act[d][0] && obsIRdy[d]) begin act[d][0] = 1'b0; iReq[d] = 1'b0; end
        if (act[d][1] && obsDRdy[d]) begin act[d][1] = 1'b0; dReq[d] = 1'b0; end
        if (!act[d][0] && c < 2800 && $urandom_range(0, 2) == 0) begin
          iAddr[d] = rndAddr();
          iReq[d]  = 1'b1;
          act[d][0] = 1'b1;
        end
        if (!act[d][1] && c < 2800 && $urandom_range(0, 2) == 0) begin
          dWe[d]    = 1'($urandom_range(0, 1));
          dBe[d]    = 4'($urandom);
          dAddr[d]  = rndAddr();
          dWdata[d] = $urandom;
          dReq[d]   = 1'b1;
          act[d][1] = 1'b1;
        end
      end
      tick();
    end
    stuck = 0;
    for (int d = 0; d < 2; d++) stuck += int'(act[d][0]) + int'(act[d][1]);
    chk("drain_all_done", 0, stuck, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
